// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message-schedule sequencer: loads one 512-bit block and streams W[0..N_ROUNDS-1].
// Optional perf counters (blk_cnt, stall_cnt) are enabled by defining SHA256_W_PERF_EN.
module sha256_w_sched_ctrl #(
    parameter int N_ROUNDS = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_word,
    output logic [5:0]   w_idx,
    output logic         w_last,
    output logic         busy
`ifdef SHA256_W_PERF_EN
    ,
    output logic [31:0]  blk_cnt,
    output logic [31:0]  stall_cnt
`endif
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [5:0] LAST_IDX = 6'(N_ROUNDS - 1);

    state_t      r_state;
    logic [5:0]  r_t;
    logic        r_valid;
    logic        r_last;
    logic [31:0] w_win [16];
    logic [31:0] w_new;
    logic        w_load;
    logic        w_abort;
    logic        w_fire;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign in_ready = (r_state == S_IDLE) & ~RST;
    assign w_load   = in_ready & in_valid;
    assign w_abort  = (r_state == S_RUN) & abort;
    // abort wins over a simultaneous handshake
    assign w_fire   = r_valid & w_ready & ~abort;
    assign w_new    = sig1(w_win[14]) + w_win[9] + sig0(w_win[1]) + w_win[0];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_win
            logic [31:0] r_word;
            assign w_win[gi] = r_word;
            if (gi < 15) begin : g_shift
                always_ff @(posedge CLK) begin
                    if (RST || w_abort)
                        r_word <= '0;
                    else if (w_load)
                        r_word <= block_in[511 - 32*gi -: 32];
                    else if (w_fire)
                        r_word <= w_win[gi + 1];
                end
            end else begin : g_top
                always_ff @(posedge CLK) begin
                    if (RST || w_abort)
                        r_word <= '0;
                    else if (w_load)
                        r_word <= block_in[31:0];
                    else if (w_fire)
                        r_word <= w_new;
                end
            end
        end
    endgenerate

`ifdef SHA256_W_PERF_EN
    logic [31:0] r_blk_cnt;
    logic [31:0] r_stall_cnt;
    assign blk_cnt   = r_blk_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_t     <= '0;
`ifdef SHA256_W_PERF_EN
            r_blk_cnt   <= '0;
            r_stall_cnt <= '0;
`endif
        end else begin
`ifdef SHA256_W_PERF_EN
            if (r_state == S_RUN && !w_ready)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_fire && r_last)
                r_blk_cnt <= r_blk_cnt + 32'd1;
`endif
            if (w_abort) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_t     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_load) begin
                            r_state <= S_RUN;
                            r_valid <= 1'b1;
                            r_last  <= 1'b0;
                            r_t     <= '0;
                        end
                    end
                    S_RUN: begin
                        if (w_fire) begin
                            r_t <= r_t + 6'd1;
                            if (r_last) begin
                                r_state <= S_IDLE;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                            end else begin
                                r_last <= ((r_t + 6'd1) == LAST_IDX);
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_valid = r_valid;
    assign w_word  = w_win[0];
    assign w_idx   = r_t;
    assign w_last  = r_last;
    assign busy    = (r_state == S_RUN);

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
// Bench for sha256_w_sched_ctrl: directed/random blocks checked against a full-array W expansion.
// Two instances (N_ROUNDS 64 and 57) share all inputs except in_valid.
module tb_sha256_w_sched_ctrl;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         abort = 1'b0;
    logic         in_valid1 = 1'b0;
    logic         in_valid2 = 1'b0;
    logic [511:0] block_in = '0;
    logic         w_ready = 1'b0;

    logic        ir1, v1, l1, b1, ir2, v2, l2, b2;
    logic [31:0] wd1, wd2;
    logic [5:0]  ix1, ix2;
    logic [31:0] blk1, st1, blk2, st2;

    int sel = 0;
    logic        o_ir, o_v, o_l, o_b;
    logic [31:0] o_wd, o_blk, o_st;
    logic [5:0]  o_ix;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_blk [2];
    int exp_stall [2];
    logic [31:0] obs_w [64];

    always #5 CLK = ~CLK;

    sha256_w_sched_ctrl #(.N_ROUNDS(64)) u_dut64 (
        .CLK(CLK), .RST(RST), .abort(abort), .in_valid(in_valid1), .in_ready(ir1),
        .block_in(block_in), .w_valid(v1), .w_ready(w_ready), .w_word(wd1),
        .w_idx(ix1), .w_last(l1), .busy(b1)
`ifdef SHA256_W_PERF_EN
        , .blk_cnt(blk1), .stall_cnt(st1)
`endif
    );

    sha256_w_sched_ctrl #(.N_ROUNDS(57)) u_dut57 (
        .CLK(CLK), .RST(RST), .abort(abort), .in_valid(in_valid2), .in_ready(ir2),
        .block_in(block_in), .w_valid(v2), .w_ready(w_ready), .w_word(wd2),
        .w_idx(ix2), .w_last(l2), .busy(b2)
`ifdef SHA256_W_PERF_EN
        , .blk_cnt(blk2), .stall_cnt(st2)
`endif
    );

`ifndef SHA256_W_PERF_EN
    assign blk1 = '0;
    assign st1  = '0;
    assign blk2 = '0;
    assign st2  = '0;
`endif

    always_comb begin
        o_ir = ir1; o_v = v1; o_l = l1; o_b = b1; o_wd = wd1; o_ix = ix1; o_blk = blk1; o_st = st1;
        if (sel == 1) begin
            o_ir = ir2; o_v = v2; o_l = l2; o_b = b2; o_wd = wd2; o_ix = ix2; o_blk = blk2; o_st = st2;
        end
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: plain array expansion of the whole schedule
    function automatic void expand(input logic [511:0] blk, output logic [31:0] w [64]);
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef SHA256_W_PERF_EN
        check({tag, "_blk"}, 64'(o_blk), 64'(exp_blk[sel]));
        check({tag, "_stall"}, 64'(o_st), 64'(exp_stall[sel]));
`endif
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Starts and ends at a negedge. act_at >= 0 injects abort (or RST) at that word index.
    task automatic stream(input logic [511:0] blk, input int sel_in, input int stall_pct,
                          input int act_at, input bit act_rst, input bit load_abort);
        logic [31:0] ref_w [64];
        int n, t, guard;
        bit rdy;
        time load_time, fire_time;
        sel = sel_in;
        n = (sel_in == 1) ? 57 : 64;
        expand(blk, ref_w);
        fire_time = 0;
        #1;
        check("load_ready", 64'(o_ir), 64'd1);
        if (sel_in == 1) in_valid2 = 1'b1; else in_valid1 = 1'b1;
        block_in = blk;
        abort = load_abort;
        @(posedge CLK);
        load_time = $time;
        @(negedge CLK);
        in_valid1 = 1'b0; in_valid2 = 1'b0; abort = 1'b0;
        block_in = rand_block();
        t = 0; guard = 0;
        while (t < n && guard < 2000) begin
            guard++;
            check("valid", 64'(o_v), 64'd1);
            check("idx", 64'(o_ix), 64'(t));
            check("word", 64'(o_wd), 64'(ref_w[t]));
            check("last", 64'(o_l), 64'(t == n - 1));
            check("busy_ready", {62'd0, o_b, o_ir}, 64'b10);
            if (act_at == t) begin
                w_ready = 1'b1;
                if (act_rst) RST = 1'b1; else abort = 1'b1;
                @(negedge CLK);
                abort = 1'b0;
                $display("[TB] dut%0d %s at t=%0d", sel, act_rst ? "reset" : "abort", t);
                check("act_valid", {62'd0, o_v, o_b}, 64'd0);
                check("act_word", 64'(o_wd), 64'd0);
                if (act_rst) begin
                    exp_blk = '{0, 0};
                    exp_stall = '{0, 0};
                    check("rst_idx", 64'(o_ix), 64'd0);
                    check("rst_ready", 64'(o_ir), 64'd0);
                    check_perf("rst");
                    RST = 1'b0;
                    @(negedge CLK);
                end else begin
                    check("abort_ready", 64'(o_ir), 64'd1);
                end
                w_ready = 1'b0;
                return;
            end
            rdy = ($urandom_range(99) >= stall_pct);
            w_ready = rdy;
            if (!rdy) exp_stall[sel]++;
            else begin
                obs_w[t] = o_wd;
                t++;
                if (t == n) exp_blk[sel]++;
            end
            @(posedge CLK);
            if (rdy && t == n) fire_time = $time;
            @(negedge CLK);
        end
        w_ready = 1'b0;
        check("word_count", 64'(t), 64'(n));
        check("end_idle", {62'd0, o_v, o_b}, 64'd0);
        check("end_ready", 64'(o_ir), 64'd1);
        if (stall_pct == 0)
            check("latency", 64'((fire_time - load_time) / 10), 64'(n));
        check_perf("end");
        $display("[TB] dut%0d block done words=%0d stall_pct=%0d", sel, t, stall_pct);
    endtask

    initial begin
        logic [511:0] abc;
        logic [511:0] b;
        exp_blk = '{0, 0};
        exp_stall = '{0, 0};
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0] = 32'h00000018;

        repeat (3) @(negedge CLK);
        check("rst_out", {o_v, o_l, o_b, o_ir}, 64'd0);
        check("rst_word", {26'd0, o_ix, o_wd}, 64'd0);
        RST = 1'b0;
        #1;
        check("rst_release_ready", 64'(o_ir), 64'd1);
        check_perf("rst");
        @(negedge CLK);

        stream(abc, 0, 0, -1, 1'b0, 1'b0);
        check("abc_w0", 64'(obs_w[0]), 64'h61626380);
        check("abc_w16", 64'(obs_w[16]), 64'h61626380);
        check("abc_w17", 64'(obs_w[17]), 64'h000F0000);

        for (int i = 0; i < 3; i++) stream(rand_block(), 0, 40, -1, 1'b0, 1'b0);

        stream(rand_block(), 0, 20, 20, 1'b0, 1'b0);
        stream(rand_block(), 0, 0, -1, 1'b0, 1'b1);

        stream(rand_block(), 0, 10, 30, 1'b1, 1'b0);
        b = rand_block();
        stream(b, 0, 30, -1, 1'b0, 1'b0);

        stream(abc, 1, 0, -1, 1'b0, 1'b0);
        stream(rand_block(), 1, 25, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
